uart_tx_scheduler: RTL and testbench

Sequences bytes out of the UART transmit `sync_fifo` into the transmit serializer. It issues single-cycle FIFO read strobes, captures the registered read data, and presents it on a valid/ready handshake. Transfers are gated by a software enable and by the synchronized modem CTS input. Output is paced in bursts of at most `BURST_LEN` bytes, separated by `GAP_CYCLES` idle cycles. It sits between the TX FIFO read port and the TX shift register.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_tx_scheduler.sv | 137 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   DEFAULT_DATA_WIDTH : default byte width, matches the TX FIFO.
//   tx_state_e         : 3-bit state encoding of the TX scheduler.
package uart_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StLoad  = 3'd2,
        StSend  = 3'd3,
        StGap   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
//   clk   : destination clock, rising edge
//   reset : synchronous, active-high; loads both flops with RESET_VALUE
//   d     : asynchronous input
//   q     : synchronized output, two cycles of latency
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Moves bytes from the TX FIFO read port to the TX serializer handshake.
// Fetches are gated by enable and the synchronized CTS, and paced in bursts
// of BURST_LEN bytes separated by GAP_CYCLES idle cycles.
//   clk, reset       : clock and synchronous active-high reset
//   enable           : permits new fetches
//   cts_n            : asynchronous active-low clear-to-send
//   fifo_empty       : FIFO empty flag
//   fifo_read_enable : single-cycle read strobe to the FIFO
//   fifo_read_data   : registered FIFO data, valid the cycle after the strobe
//   tx_valid/tx_data : byte offered to the serializer
//   tx_ready         : serializer accept
//   busy             : scheduler not idle
//   bytes_sent       : accepted byte count, wraps
//   burst_done       : one-cycle pulse after a full burst
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned GAP_CYCLES = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  cts_n,
    input  logic                  fifo_empty,
    output logic                  fifo_read_enable,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  bytes_sent,
    output logic                  burst_done
);

    // burst_cnt only needs to hold 0..BURST_LEN-1; gap_cnt holds 0..GAP_CYCLES.
    localparam int unsigned BurstW = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned GapW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    tx_state_e         state;
    logic [BurstW-1:0] burst_cnt;
    logic [GapW-1:0]   gap_cnt;
    logic              cts_n_sync;
    logic              cts_ok;
    logic              go;
    logic              burst_last;

    // Idle level of cts_n is high (not clear to send).
    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_cts_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cts_n),
        .q     (cts_n_sync)
    );

    assign cts_ok     = ~cts_n_sync;
    assign go         = enable & cts_ok & ~fifo_empty;
    assign burst_last = (BURST_LEN != 0) && (burst_cnt == BurstW'(BURST_LEN - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= StIdle;
            fifo_read_enable <= 1'b0;
            tx_valid         <= 1'b0;
            tx_data          <= '0;
            bytes_sent       <= '0;
            burst_done       <= 1'b0;
            busy             <= 1'b0;
            burst_cnt        <= '0;
            gap_cnt          <= '0;
        end else begin
            fifo_read_enable <= 1'b0;
            burst_done       <= 1'b0;
            case (state)
                StIdle: begin
                    if (go) begin
                        state            <= StFetch;
                        fifo_read_enable <= 1'b1;
                        busy             <= 1'b1;
                    end
                end
                StFetch: begin
                    state <= StLoad;
                end
                StLoad: begin
                    tx_data  <= fifo_read_data;
                    tx_valid <= 1'b1;
                    state    <= StSend;
                end
                StSend: begin
                    if (tx_ready) begin
                        tx_valid   <= 1'b0;
                        bytes_sent <= bytes_sent + 1'b1;
                        if (burst_last) begin
                            burst_cnt  <= '0;
                            burst_done <= 1'b1;
                            gap_cnt    <= GapW'(GAP_CYCLES);
                            state      <= StGap;
                        end else begin
                            // Unlimited bursts never need the counter.
                            if (BURST_LEN != 0) begin
                                burst_cnt <= burst_cnt + 1'b1;
                            end
                            if (go) begin
                                state            <= StFetch;
                                fifo_read_enable <= 1'b1;
                            end else begin
                                state <= StIdle;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                StGap: begin
                    // Leave when the decremented count reaches zero; a zero load
                    // still spends exactly one cycle here.
                    if (gap_cnt <= GapW'(1)) begin
                        gap_cnt <= '0;
                        state   <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler (BURST_LEN=4, GAP_CYCLES=5, CNT_WIDTH=4).
// A queue models the FIFO; expectations come from handshake counting and
// the documented cycle relationships.
module tb_uart_tx_scheduler;

    localparam int unsigned Burst = 4;
    localparam int unsigned Gap   = 5;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       cts_n;
    logic       fifo_empty;
    logic       fifo_read_enable;
    logic [7:0] fifo_read_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic [3:0] bytes_sent;
    logic       burst_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sent_model = 0;

    logic [7:0] fq[$];     // FIFO contents
    logic [7:0] exp_q[$];  // bytes read from the FIFO, awaiting handshake
    int strobe_log[$];
    int hs_log[$];
    int bd_log[$];

    uart_tx_scheduler #(
        .DATA_WIDTH (8),
        .BURST_LEN  (Burst),
        .GAP_CYCLES (Gap),
        .CNT_WIDTH  (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .cts_n            (cts_n),
        .fifo_empty       (fifo_empty),
        .fifo_read_enable (fifo_read_enable),
        .fifo_read_data   (fifo_read_data),
        .tx_valid         (tx_valid),
        .tx_data          (tx_data),
        .tx_ready         (tx_ready),
        .busy             (busy),
        .bytes_sent       (bytes_sent),
        .burst_done       (burst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe the current cycle, advance one clock, update the FIFO model,
    // then check the per-cycle invariants.
    task automatic cycle();
        logic       rd;
        logic       rst;
        logic       hs;
        logic       hold;
        logic [7:0] held;
        logic [31:0] exp_byte;
        rd   = fifo_read_enable;
        rst  = reset;
        hs   = tx_valid && tx_ready && !reset;
        hold = tx_valid && !tx_ready && !reset;
        held = tx_data;
        if (fifo_read_enable === 1'b1) begin
            check("strobe_not_empty", 32'(fifo_empty), 32'd0);
            strobe_log.push_back(cyc);
        end
        if (hs) begin
            exp_byte = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'h100;
            check("tx_data_order", 32'(tx_data), exp_byte);
            sent_model++;
            hs_log.push_back(cyc);
        end
        if (burst_done === 1'b1) bd_log.push_back(cyc);
        @(posedge clk);
        #1;
        cyc++;
        if (rd === 1'b1) begin
            if (fq.size() != 0) begin
                fifo_read_data = fq.pop_front();
                exp_q.push_back(fifo_read_data);
            end
            fifo_empty = (fq.size() == 0);
        end
        if (rst) begin
            sent_model = 0;
            exp_q.delete();
        end
        check("bytes_sent", 32'(bytes_sent), 32'(sent_model % 16));
        check("burst_done", 32'(burst_done), 32'(hs && (sent_model % Burst == 0)));
        if (hold) begin
            check("hold_valid", 32'(tx_valid), 32'd1);
            check("hold_data", 32'(tx_data), 32'(held));
        end
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (tx_valid === 1'b1) break;
            cycle();
        end
        check(tag, 32'(tx_valid), 32'd1);
    endtask

    task automatic run_until_hs(input string tag, input int n, input int budget);
        int left;
        left = budget;
        while (hs_log.size() < n && left > 0) begin
            cycle();
            left--;
        end
        check(tag, 32'(hs_log.size()), 32'(n));
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        enable   = 1'b0;
        tx_ready = 1'b0;
        cts_n    = 1'b0;
        cycle();
        cycle();
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobe", 32'(fifo_read_enable), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        reset = 1'b0;
        fq.delete();
        fifo_empty = 1'b1;
        strobe_log.delete();
        hs_log.delete();
        bd_log.delete();
        repeat (3) cycle();
    endtask

    initial begin
        int n;
        int c;
        reset          = 1'b1;
        enable         = 1'b0;
        cts_n          = 1'b1;
        tx_ready       = 1'b0;
        fifo_empty     = 1'b1;
        fifo_read_data = 8'h00;

        // Single byte launch latency.
        do_reset();
        push(8'h55);
        tx_ready = 1'b1;
        enable   = 1'b1;
        n = cyc;
        cycle();
        check("t1_strobe_n1", 32'(fifo_read_enable), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        cycle();
        check("t1_strobe_n2", 32'(fifo_read_enable), 32'd0);
        check("t1_valid_n2", 32'(tx_valid), 32'd0);
        cycle();
        check("t1_valid_n3", 32'(tx_valid), 32'd1);
        check("t1_data", 32'(tx_data), 32'h55);
        check("t1_latency", 32'(cyc - n), 32'd3);
        cycle();
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_sent", 32'(bytes_sent), 32'd1);
        repeat (3) cycle();
        check("t1_strobes", 32'(strobe_log.size()), 32'd1);

        // Backpressure on the second of three bytes.
        do_reset();
        push(8'h01);
        push(8'h02);
        push(8'h03);
        enable = 1'b1;
        wait_valid("t2_valid1", 20);
        tx_ready = 1'b1;
        cycle();
        tx_ready = 1'b0;
        wait_valid("t2_valid2", 20);
        for (int i = 0; i < 10; i++) begin
            check("t2_stall_data", 32'(tx_data), 32'h02);
            cycle();
        end
        check("t2_no_extra_strobe", 32'(strobe_log.size()), 32'd2);
        tx_ready = 1'b1;
        run_until_hs("t2_hs", 3, 30);
        repeat (4) cycle();
        check("t2_sent", 32'(bytes_sent), 32'd3);
        check("t2_strobes", 32'(strobe_log.size()), 32'd3);

        // Burst of 4 then a gap, 6 bytes total.
        do_reset();
        for (int i = 0; i < 6; i++) push(8'($urandom));
        tx_ready = 1'b1;
        enable   = 1'b1;
        run_until_hs("t3_hs", 6, 200);
        repeat (3) cycle();
        check("t3_bd_count", 32'(bd_log.size()), 32'd1);
        if (hs_log.size() == 6 && strobe_log.size() == 6 && bd_log.size() == 1) begin
            check("t3_bd_cycle", 32'(bd_log[0] - hs_log[3]), 32'd1);
            check("t3_gap_strobe", 32'(strobe_log[4] - hs_log[3]), 32'(Gap + 2));
            check("t3_b2b_strobe", 32'(strobe_log[1] - hs_log[0]), 32'd1);
            check("t3_peak_rate", 32'(hs_log[1] - hs_log[0]), 32'd3);
        end
        check("t3_sent", 32'(bytes_sent), 32'd6);

        // CTS raised while a byte waits in SEND.
        do_reset();
        push(8'($urandom));
        push(8'($urandom));
        enable = 1'b1;
        wait_valid("t4_valid1", 20);
        cts_n = 1'b1;
        repeat (3) cycle();
        tx_ready = 1'b1;
        cycle();
        repeat (6) cycle();
        check("t4_first_done", 32'(bytes_sent), 32'd1);
        check("t4_blocked", 32'(strobe_log.size()), 32'd1);
        cts_n = 1'b0;
        c = cyc;
        for (int i = 0; i < 10 && strobe_log.size() < 2; i++) cycle();
        check("t4_resume_count", 32'(strobe_log.size()), 32'd2);
        if (strobe_log.size() == 2) check("t4_resume_cycle", 32'(strobe_log[1] - c), 32'd3);
        run_until_hs("t4_hs", 2, 20);

        // Reset while a byte waits in SEND.
        do_reset();
        push(8'($urandom));
        enable = 1'b1;
        wait_valid("t5_valid", 20);
        check("t5_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        cycle();
        check("t5_valid", 32'(tx_valid), 32'd0);
        check("t5_busy_clr", 32'(busy), 32'd0);
        check("t5_sent", 32'(bytes_sent), 32'd0);
        reset = 1'b0;
        strobe_log.delete();
        repeat (10) cycle();
        check("t5_no_strobe", 32'(strobe_log.size()), 32'd0);

        // Random backpressure over 17 bytes; count wraps at 16.
        do_reset();
        for (int i = 0; i < 17; i++) push(8'($urandom));
        enable = 1'b1;
        n = 2000;
        while (hs_log.size() < 17 && n > 0) begin
            tx_ready = 1'($urandom_range(0, 1));
            cycle();
            n--;
        end
        check("t6_hs", 32'(hs_log.size()), 32'd17);
        tx_ready = 1'b0;
        repeat (3) cycle();
        check("t6_wrap", 32'(bytes_sent), 32'd1);
        check("t6_bd_count", 32'(bd_log.size()), 32'd4);
        check("t6_strobes", 32'(strobe_log.size()), 32'd17);
        if (hs_log.size() == 17 && strobe_log.size() == 17) begin
            for (int i = 0; i < 4; i++) begin
                check("t6_gap_strobe", 32'(strobe_log[4 * i + 4] - hs_log[4 * i + 3]),
                      32'(Gap + 2));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
